// File: rtl/axi_stream_crc_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_stream_crc_pkt_arbiter
// Description : Packet-granular round-robin arbiter sharing one sideband-CRC
//               append datapath between NUM_SRC AXI-Stream packet sources.
//               The grant is locked from a packet's first beat to its tlast
//               beat. Beats, the source's CRC and the source index leave
//               through one registered output stage.
//               Optional build macro: AXIS_CRC_ARB_BACK2BACK_EN
//                 defined   -> re-arbitrate on the tlast beat (no bubble)
//                 undefined -> one IDLE bubble between packets
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_crc_pkt_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int CRC_WIDTH  = 32,
  parameter int TID_WIDTH  = $clog2(NUM_SRC)
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_SRC*KEEP_BYTES-1:0]    s_tkeep,
  input  logic [NUM_SRC-1:0]               s_tlast,
  input  logic [NUM_SRC-1:0]               s_tvalid,
  output logic [NUM_SRC-1:0]               s_tready,
  input  logic [NUM_SRC*CRC_WIDTH-1:0]     s_crc,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [KEEP_BYTES-1:0]            m_tkeep,
  output logic                             m_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [CRC_WIDTH-1:0]             m_crc,
  output logic [TID_WIDTH-1:0]             m_tid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [TID_WIDTH-1:0]    grant_q, grant_d;
  logic [TID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [KEEP_BYTES-1:0]   m_tkeep_q, m_tkeep_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [CRC_WIDTH-1:0]    m_crc_q, m_crc_d;
  logic [TID_WIDTH-1:0]    m_tid_q, m_tid_d;

  logic                    out_ready;
  logic                    accept;
  logic [TID_WIDTH:0]      idle_pick;

  // Per-source views of the flattened input buses
  logic [DATA_WIDTH-1:0]   src_tdata [NUM_SRC];
  logic [KEEP_BYTES-1:0]   src_tkeep [NUM_SRC];
  logic [CRC_WIDTH-1:0]    src_crc   [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_tdata[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign src_tkeep[i] = s_tkeep[i*KEEP_BYTES +: KEEP_BYTES];
    assign src_crc[i]   = s_crc[i*CRC_WIDTH +: CRC_WIDTH];
  end

  // Modulo-NUM_SRC increment; explicit compare so non-power-of-2 counts wrap
  function automatic logic [TID_WIDTH-1:0] wrap_inc(input logic [TID_WIDTH-1:0] v);
    if (v == TID_WIDTH'(NUM_SRC - 1)) begin
      return '0;
    end
    return v + TID_WIDTH'(1);
  endfunction

  // First set request at start, start+1, ... (mod NUM_SRC); MSB = found
  function automatic logic [TID_WIDTH:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [TID_WIDTH-1:0] start);
    logic                 found;
    logic [TID_WIDTH-1:0] idx;
    logic [TID_WIDTH-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = start;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = wrap_inc(cand);
    end
    return {found, idx};
  endfunction

`ifdef AXIS_CRC_ARB_BACK2BACK_EN
  logic [NUM_SRC-1:0]      other_req;
  logic [TID_WIDTH:0]      b2b_pick;
`endif

  // Next-state, grant, pointer, ready and output-stage computation
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q;
    m_crc_d    = m_crc_q;
    m_tid_d    = m_tid_q;
    s_tready   = '0;
    accept     = 1'b0;
    out_ready  = !m_tvalid_q || m_tready;
    idle_pick  = rr_pick(s_tvalid, rr_ptr_q);
`ifdef AXIS_CRC_ARB_BACK2BACK_EN
    // The finishing source's tvalid belongs to its current tlast beat, so it
    // is left out here; if it is the only one with more work it wins the
    // following IDLE arbitration from the advanced pointer.
    other_req          = s_tvalid;
    other_req[grant_q] = 1'b0;
    b2b_pick           = rr_pick(other_req, wrap_inc(grant_q));
`endif

    case (state_q)
      IDLE: begin
        if (idle_pick[TID_WIDTH]) begin
          grant_d = idle_pick[TID_WIDTH-1:0];
          state_d = XFER;
        end
      end
      XFER: begin
        s_tready[grant_q] = out_ready;
        accept            = s_tvalid[grant_q] && out_ready;
        if (accept && s_tlast[grant_q]) begin
          rr_ptr_d = wrap_inc(grant_q);
          state_d  = IDLE;
`ifdef AXIS_CRC_ARB_BACK2BACK_EN
          if (b2b_pick[TID_WIDTH]) begin
            grant_d = b2b_pick[TID_WIDTH-1:0];
            state_d = XFER;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output register: load on an accepted beat, drain when the sink takes it
    if (accept) begin
      m_tdata_d  = src_tdata[grant_q];
      m_tkeep_d  = src_tkeep[grant_q];
      m_tlast_d  = s_tlast[grant_q];
      m_crc_d    = src_crc[grant_q];
      m_tid_d    = grant_q;
      m_tvalid_d = 1'b1;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any in-flight beat
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_crc_q    <= '0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tvalid_q <= m_tvalid_d;
      m_crc_q    <= m_crc_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
  assign m_crc    = m_crc_q;
  assign m_tid    = m_tid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_crc_pkt_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_crc_pkt_arbiter
// Description : Self-checking bench for axi_stream_crc_pkt_arbiter. Source
//               drivers replay per-source packet queues; a packet-level
//               round-robin model predicts the output beat order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_crc_pkt_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KB = DW / 8;
  localparam int CW = 32;
  localparam int TW = 2;
`ifdef AXIS_CRC_ARB_BACK2BACK_EN
  localparam int PKT_GAP = 1;
`else
  localparam int PKT_GAP = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              srst;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KB-1:0]  s_tkeep;
  logic [NS-1:0]     s_tlast, s_tvalid;
  logic [NS*CW-1:0]  s_crc;
  logic              m_tready;

  logic [NS-1:0]     s_tready4;
  logic [DW-1:0]     m_tdata4;
  logic [KB-1:0]     m_tkeep4;
  logic              m_tlast4, m_tvalid4;
  logic [CW-1:0]     m_crc4;
  logic [TW-1:0]     m_tid4;

  logic [2:0]        s_tready3;
  logic [DW-1:0]     m_tdata3;
  logic [KB-1:0]     m_tkeep3;
  logic              m_tlast3, m_tvalid3;
  logic [CW-1:0]     m_crc3;
  logic [TW-1:0]     m_tid3;

  axi_stream_crc_pkt_arbiter #(
    .NUM_SRC(4), .DATA_WIDTH(DW), .KEEP_BYTES(KB), .CRC_WIDTH(CW), .TID_WIDTH(TW)
  ) u_dut (
    .clk(clk), .srst(srst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready4), .s_crc(s_crc),
    .m_tdata(m_tdata4), .m_tkeep(m_tkeep4), .m_tlast(m_tlast4), .m_tvalid(m_tvalid4),
    .m_tready(m_tready), .m_crc(m_crc4), .m_tid(m_tid4)
  );

  axi_stream_crc_pkt_arbiter #(
    .NUM_SRC(3), .DATA_WIDTH(DW), .KEEP_BYTES(KB), .CRC_WIDTH(CW), .TID_WIDTH(TW)
  ) u_dut3 (
    .clk(clk), .srst(srst),
    .s_tdata(s_tdata[3*DW-1:0]), .s_tkeep(s_tkeep[3*KB-1:0]), .s_tlast(s_tlast[2:0]),
    .s_tvalid(s_tvalid[2:0]), .s_tready(s_tready3), .s_crc(s_crc[3*CW-1:0]),
    .m_tdata(m_tdata3), .m_tkeep(m_tkeep3), .m_tlast(m_tlast3), .m_tvalid(m_tvalid3),
    .m_tready(m_tready), .m_crc(m_crc3), .m_tid(m_tid3)
  );

  // Monitor view: whichever instance the current phase exercises
  bit            use3 = 1'b0;
  logic [NS-1:0] mon_s_tready;
  logic [DW-1:0] mon_d;
  logic [KB-1:0] mon_k;
  logic          mon_l, mon_v;
  logic [CW-1:0] mon_c;
  logic [TW-1:0] mon_t;
  always_comb begin
    if (use3) begin
      mon_s_tready = {1'b0, s_tready3};
      mon_d = m_tdata3; mon_k = m_tkeep3; mon_l = m_tlast3;
      mon_v = m_tvalid3; mon_c = m_crc3; mon_t = m_tid3;
    end else begin
      mon_s_tready = s_tready4;
      mon_d = m_tdata4; mon_k = m_tkeep4; mon_l = m_tlast4;
      mon_v = m_tvalid4; mon_c = m_crc4; mon_t = m_tid4;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KB-1:0] k;
    logic          l;
    logic [CW-1:0] c;
    logic [TW-1:0] t;
  } beat_t;

  beat_t srcq [NS][$];
  beat_t expq [$];
  int    checks = 0;
  int    errors = 0;
  int    model_ptr = 0;
  int    step_no = 0;
  int    first_valid_step = -1;
  int    last_fire_step = -1;
  bit    last_fire_was_last = 1'b0;
  bit    timing_chk = 1'b0;
  bit    sb_en = 1'b1;
  bit    bp = 1'b0;
  int    gap_len = 0;
  int    stall [NS];
  bit    first_beat [NS];
  logic [NS-1:0] acc_p = '0;
  bit    fire_p = 1'b0;
  beat_t prev_b;
  bit    prev_v = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_pkt(input int src, input int nb, input bit keep0_last);
    beat_t b;
    logic [CW-1:0] crc;
    crc = $urandom;
    for (int i = 0; i < nb; i++) begin
      b.d = $urandom;
      b.l = (i == nb - 1);
      b.k = (b.l && keep0_last) ? '0 : KB'($urandom);
      b.c = crc;
      b.t = TW'(src);
      srcq[src].push_back(b);
    end
  endtask

  // Reference: whole packets, round-robin over non-empty sources from ptr
  task automatic build_expected();
    beat_t tmp [NS][$];
    beat_t b;
    int n, pick;
    bit any;
    n = use3 ? 3 : NS;
    for (int i = 0; i < NS; i++) tmp[i] = srcq[i];
    for (int guard = 0; guard < 1000; guard++) begin
      any = 1'b0;
      pick = 0;
      for (int k = 0; k < n; k++) begin
        if (!any && tmp[(model_ptr + k) % n].size() > 0) begin
          any = 1'b1;
          pick = (model_ptr + k) % n;
        end
      end
      if (!any) break;
      do begin
        b = tmp[pick].pop_front();
        b.t = TW'(pick);
        expq.push_back(b);
      end while (!b.l);
      model_ptr = (pick + 1) % n;
    end
  endtask

  task automatic step(input bit rst_v);
    beat_t e, b;
    bit held, v;
    @(negedge clk);
    step_no++;
    // Consequences of the previous rising edge
    if (fire_p && sb_en) begin
      chk("beat_expected", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("tdata", 64'(prev_b.d), 64'(e.d));
        chk("tkeep", 64'(prev_b.k), 64'(e.k));
        chk("tlast", 64'(prev_b.l), 64'(e.l));
        chk("crc",   64'(prev_b.c), 64'(e.c));
        chk("tid",   64'(prev_b.t), 64'(e.t));
      end
      if (timing_chk && last_fire_step >= 0)
        chk("beat_spacing", 64'(step_no - last_fire_step),
            64'(last_fire_was_last ? PKT_GAP : 1));
      last_fire_step     = step_no;
      last_fire_was_last = prev_b.l;
    end
    for (int i = 0; i < NS; i++) begin
      if (acc_p[i] && srcq[i].size() > 0) begin
        b = srcq[i].pop_front();
        first_beat[i] = b.l;
        stall[i] = b.l ? 0 : ((gap_len < 0) ? int'($urandom_range(0, 3)) : gap_len);
      end
    end
    if (prev_v && !prev_ready && !prev_rst) begin
      chk("stall_valid", 64'(mon_v), 64'd1);
      chk("stall_tdata", 64'(mon_d), 64'(prev_b.d));
      chk("stall_tlast", 64'(mon_l), 64'(prev_b.l));
      chk("stall_tid",   64'(mon_t), 64'(prev_b.t));
    end
    if (first_valid_step < 0 && mon_v) first_valid_step = step_no;
    // Drive the next cycle
    srst     = rst_v;
    m_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int i = 0; i < NS; i++) begin
      held = s_tvalid[i] && !acc_p[i] && (srcq[i].size() > 0);
      v = 1'b0;
      if (srcq[i].size() > 0) begin
        if (held || first_beat[i]) v = 1'b1;
        else if (stall[i] > 0) stall[i]--;
        else v = 1'b1;
        b = srcq[i][0];
      end else begin
        b = '0;
      end
      s_tvalid[i]          = v;
      s_tdata[i*DW +: DW]  = b.d;
      s_tkeep[i*KB +: KB]  = b.k;
      s_tlast[i]           = b.l;
      s_crc[i*CW +: CW]    = b.c;
    end
    #1;
    acc_p  = s_tvalid & mon_s_tready;
    fire_p = mon_v && m_tready;
    prev_b = '{d: mon_d, k: mon_k, l: mon_l, c: mon_c, t: mon_t};
    prev_v = mon_v;
    prev_ready = m_tready;
    prev_rst = rst_v;
    chk("tready_onehot0", 64'($onehot0(mon_s_tready)), 64'd1);
    if (mon_v && !m_tready) chk("tready_during_stall", 64'(mon_s_tready), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    model_ptr = 0;
    last_fire_step = -1;
    for (int i = 0; i < NS; i++) begin
      first_beat[i] = 1'b1;
      stall[i] = 0;
    end
    for (int c = 0; c < cycles; c++) step(1'b1);
  endtask

  task automatic run_phase(input string name, input int max_steps);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max_steps) begin
      step(1'b0);
      n++;
      busy = fire_p || (expq.size() > 0) || mon_v;
      for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) busy = 1'b1;
    end
    chk({name, "_done"}, 64'(busy), 64'd0);
    chk({name, "_expq_empty"}, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int ps;
    srst = 1'b1; m_tready = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_crc = '0;
    prev_b = '0;
    for (int i = 0; i < NS; i++) begin first_beat[i] = 1'b1; stall[i] = 0; end

    // Reset with every source requesting, then round-robin of 2-beat packets
    for (int s = 0; s < NS; s++) gen_pkt(s, 2, 1'b0);
    gen_pkt(0, 2, 1'b0);
    do_reset(3);
    chk("rst_m_tvalid", 64'(mon_v), 64'd0);
    chk("rst_m_tlast",  64'(mon_l), 64'd0);
    chk("rst_m_tdata",  64'(mon_d), 64'd0);
    chk("rst_m_tkeep",  64'(mon_k), 64'd0);
    chk("rst_m_crc",    64'(mon_c), 64'd0);
    chk("rst_m_tid",    64'(mon_t), 64'd0);
    chk("rst_s_tready", 64'(mon_s_tready), 64'd0);
    build_expected();
    timing_chk = 1'b1;
    first_valid_step = -1;
    ps = step_no;
    run_phase("round_robin", 200);
    chk("first_valid_latency", 64'(first_valid_step - ps), 64'd3);
    timing_chk = 1'b0;

    // Backpressure on one 4-beat packet
    do_reset(2);
    bp = 1'b1;
    gen_pkt(2, 4, 1'b0);
    build_expected();
    run_phase("backpressure", 300);

    // Granted source pauses mid-packet while another requests
    do_reset(2);
    bp = 1'b0; gap_len = 5;
    gen_pkt(1, 4, 1'b0);
    gen_pkt(3, 2, 1'b0);
    build_expected();
    run_phase("midpkt_gap", 300);

    // Randomized rounds, pointer carried across rounds
    bp = 1'b1; gap_len = -1;
    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < NS; s++)
        for (int p = 0; p < int'($urandom_range(0, 2)); p++)
          gen_pkt(s, int'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0));
      build_expected();
      run_phase("random", 3000);
    end

    // Reset in the middle of a packet
    do_reset(2);
    bp = 1'b0; gap_len = 0;
    gen_pkt(1, 2, 1'b0);
    build_expected();
    run_phase("pre_reset", 100);
    gen_pkt(2, 3, 1'b0);
    sb_en = 1'b0;
    first_valid_step = -1;
    for (int n = 0; n < 20 && first_valid_step < 0; n++) step(1'b0);
    chk("midpkt_started", 64'(first_valid_step >= 0), 64'd1);
    step(1'b1);
    @(posedge clk);
    #1;
    chk("reset_midpkt_valid", 64'(mon_v), 64'd0);
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      first_beat[i] = 1'b1;
      stall[i] = 0;
    end
    expq.delete();
    acc_p = '0; fire_p = 1'b0; prev_v = 1'b0;
    model_ptr = 0; last_fire_step = -1;
    sb_en = 1'b1;
    gen_pkt(3, 1, 1'b0);
    gen_pkt(0, 2, 1'b0);
    build_expected();
    run_phase("post_reset", 200);

    // Three sources: wrap from pointer 2, single-beat packets with tkeep=0
    use3 = 1'b1;
    do_reset(2);
    gen_pkt(1, 1, 1'b1);
    build_expected();
    run_phase("wrap_setup", 100);
    gen_pkt(0, 1, 1'b1);
    gen_pkt(2, 1, 1'b0);
    build_expected();
    run_phase("wrap", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_stream_crc_pkt_arbiter.md
Name: axi_stream_crc_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream sideband-CRC append datapath between NUM_SRC AXI-Stream packet sources.
- Each source presents its packet beats plus a per-source CRC sideband.
- The block locks the grant to one source for a whole packet, from the first beat to the tlast beat.
- It forwards beats, the source's CRC and the source index through a single registered output stage to the CRC inserter.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_WIDTH, 512, tdata width in bits.
- KEEP_BYTES, DATA_WIDTH/8, tkeep width.
- CRC_WIDTH, 32, CRC sideband width.
- TID_WIDTH, $clog2(NUM_SRC), source-index width.

Ports:
- clk  in  1  clock.
- srst  in  1  reset.
- s_tdata  in  NUM_SRC*DATA_WIDTH  source data; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_tkeep  in  NUM_SRC*KEEP_BYTES  source byte enables.
- s_tlast  in  NUM_SRC  per-source end of packet.
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tready  out  NUM_SRC  per-source ready.
- s_crc  in  NUM_SRC*CRC_WIDTH  per-source CRC; sampled with every accepted beat, meaningful on the tlast beat.
- m_tdata  out  DATA_WIDTH  data to the CRC inserter.
- m_tkeep  out  KEEP_BYTES  byte enables.
- m_tlast  out  1  end of packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  sink ready.
- m_crc  out  CRC_WIDTH  CRC of the granted source, registered with the beat.
- m_tid  out  TID_WIDTH  index of the granted source.

Behaviour:
- Reset: srst is synchronous, active-high; clock is clk.
  - On reset: m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_crc=0, m_tid=0, s_tready=0, rr_ptr=0, grant=0, state=IDLE.
- FSM states: IDLE, XFER.
- IDLE:
  - s_tready is all 0.
  - If any s_tvalid=1, select the first requesting index searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Register that index into grant and go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - s_tready[grant] = (!m_tvalid || m_tready); all other s_tready bits are 0.
  - Beat accepted = s_tvalid[grant] && s_tready[grant].
  - On an accepted beat: register tdata, tkeep, tlast, s_crc slice and grant into m_*; set m_tvalid=1 on the next edge.
  - On an accepted beat with s_tlast[grant]=1: rr_ptr <= (grant+1) mod NUM_SRC (wraps NUM_SRC-1 -> 0); next state IDLE.
- Output stage:
  - If m_tvalid && m_tready and no new beat is accepted, clear m_tvalid next edge.
  - While m_tvalid && !m_tready, all m_* hold stable (AXI rule).
- Latency:
  - 1 cycle from an accepted source beat to m_tvalid.
  - Full throughput within a packet.
  - 1 bubble cycle (IDLE) between packets.
- Boundary conditions:
  - Granted source drops tvalid mid-packet: grant is held indefinitely; other sources stall; no timeout.
  - Single-beat packet (tlast on the first beat): valid; costs IDLE plus one XFER cycle.
  - tlast beat with tkeep=0: forwarded unchanged.
  - New requests arriving in XFER: ignored until the next IDLE.
  - Non-granted source tvalid: never consumed.
  - srst mid-packet: output beat dropped, m_tvalid=0 immediately on the next edge, grant released, rr_ptr=0. Sources own recovery of partial packets.
  - NUM_SRC not a power of 2: wrap uses an explicit compare, not bit truncation.

Optional Feature:
- Macro AXIS_CRC_ARB_BACK2BACK_EN.
- Defined:
  - On the accepted tlast beat in XFER, arbitration runs in the same cycle over the other requesters, starting at (grant+1) mod NUM_SRC.
  - If a requester exists, go directly to XFER with the new grant. No bubble; the next packet's first beat may be accepted the following cycle.
  - If no requester exists, go to IDLE.
  - The finishing source is lowest priority and is considered only if it is the sole requester.
- Undefined: behaviour as above, always returning to IDLE.

Test Plan:
- Reset check: hold srst 3 cycles with all s_tvalid=1 -> all m_* = 0, s_tready=0; m_tvalid rises on the 3rd cycle after srst falls (IDLE, XFER accept, then m_tvalid), carrying source 0's first beat.
- Round-robin: sources 0..3 each present a 2-beat packet continuously, m_tready=1 -> m_tid sequence 0,0,1,1,2,2,3,3,0,0; m_crc on each tlast beat equals that source's s_crc; 1 idle cycle between packets (0 idle cycles with the macro).
- Backpressure: a 4-beat packet from source 2 with m_tready toggling 1,0,0,1,... -> m_* stable while m_tready=0; s_tready[2]=0 during stall; all 4 beats delivered in order, tlast only on beat 4.
- Mid-packet gap: source 1 drops tvalid for 5 cycles after beat 1 while source 3 requests -> no source-3 beat appears until source 1's tlast; then m_tid=3.
- Wrap and non-power-of-2: NUM_SRC=3, rr_ptr=2, sources 0 and 2 request -> grant 2, then 0.
- Reset mid-packet: srst asserted during beat 2 of 3 -> m_tvalid=0 next cycle; after release, source 0 is granted first if requesting.
